// File: rtl/scratchpad_port_arbiter_if.sv
// scratchpad_port_arbiter_if: requester, readback and RAM signals of the scratchpad port arbiter
interface scratchpad_port_arbiter_if #(
    parameter int ADDR_SIZE = 10,
    parameter int WORD_SIZE = 16
);
    logic                 res_valid;
    logic [ADDR_SIZE-1:0] res_addr;
    logic [WORD_SIZE-1:0] res_data;
    logic                 hw_valid;
    logic                 hw_ready;
    logic [ADDR_SIZE-1:0] hw_addr;
    logic [WORD_SIZE-1:0] hw_data;
    logic                 hr_valid;
    logic                 hr_ready;
    logic [ADDR_SIZE-1:0] hr_addr;
    logic                 hr_rvalid;
    logic [WORD_SIZE-1:0] hr_rdata;
    logic                 mem_en;
    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [WORD_SIZE-1:0] mem_rdata;
    logic [1:0]           gnt_src;
    logic                 idle;

    modport slave (
        input  res_valid, res_addr, res_data,
        input  hw_valid, hw_addr, hw_data,
        input  hr_valid, hr_addr, mem_rdata,
        output hw_ready, hr_ready, hr_rvalid, hr_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, gnt_src, idle
    );

    modport master (
        output res_valid, res_addr, res_data,
        output hw_valid, hw_addr, hw_data,
        output hr_valid, hr_addr, mem_rdata,
        input  hw_ready, hr_ready, hr_rvalid, hr_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, gnt_src, idle
    );
endinterface

// File: rtl/scratchpad_port_arbiter.sv
// scratchpad_port_arbiter: shares a single-port scratchpad between result writeback, a buffered host write and a host read
module scratchpad_port_arbiter #(
    parameter int ADDR_SIZE   = 10,
    parameter int WORD_SIZE   = 16,
    parameter int WFIFO_DEPTH = 4
) (
    input logic clk,
    input logic rst_n,
    scratchpad_port_arbiter_if.slave bus
);
    localparam int PW = $clog2(WFIFO_DEPTH);

    typedef enum logic [1:0] {SRC_NONE, SRC_RES, SRC_HW, SRC_HR} src_e;

    logic [ADDR_SIZE-1:0] fifo_addr_q [WFIFO_DEPTH];
    logic [WORD_SIZE-1:0] fifo_data_q [WFIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [PW:0]          cnt_q;
    logic                 rr_q, rr_d;
    logic                 rd_inflight_q, rvalid_q;
    logic                 mem_en_q, mem_we_q;
    logic [ADDR_SIZE-1:0] mem_addr_q, addr_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, wdata_d;
    src_e                 gnt_q, src_d;
    logic                 full, empty, push, pop, hazard, rd_elig, contested;

    assign full      = cnt_q[PW];
    assign empty     = cnt_q == '0;
    assign push      = bus.hw_valid & ~full;
    assign pop       = src_d == SRC_HW;
    assign rd_elig   = bus.hr_valid & ~hazard & ~rd_inflight_q;
    assign contested = ~bus.res_valid & ~empty & rd_elig;

    // a read must not overtake a queued or just-arriving write to the same word
    always_comb begin
        hazard = push && bus.hw_addr == bus.hr_addr;
        for (int i = 0; i < WFIFO_DEPTH; i++)
            if ({1'b0, PW'(i) - rd_ptr_q} < cnt_q && fifo_addr_q[i] == bus.hr_addr) hazard = 1'b1;
    end

    // rr_q = 1 means the host read wins the next contested cycle
    assign src_d = bus.res_valid ? SRC_RES :
                   contested     ? (rr_q ? SRC_HR : SRC_HW) :
                   !empty        ? SRC_HW :
                   rd_elig       ? SRC_HR : SRC_NONE;
    assign rr_d  = contested ? ~rr_q : rr_q;

    assign addr_d  = src_d == SRC_RES ? bus.res_addr :
                     src_d == SRC_HW  ? fifo_addr_q[rd_ptr_q] : bus.hr_addr;
    assign wdata_d = src_d == SRC_RES ? bus.res_data : fifo_data_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= bus.hw_addr;
            fifo_data_q[wr_ptr_q] <= bus.hw_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
            rr_q          <= 1'b0;
            rd_inflight_q <= 1'b0;
            rvalid_q      <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            gnt_q         <= SRC_NONE;
        end else begin
            wr_ptr_q      <= wr_ptr_q + PW'(push);
            rd_ptr_q      <= rd_ptr_q + PW'(pop);
            cnt_q         <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
            rr_q          <= rr_d;
            rd_inflight_q <= src_d == SRC_HR;
            rvalid_q      <= rd_inflight_q;
            mem_en_q      <= src_d != SRC_NONE;
            gnt_q         <= src_d;
            if (src_d != SRC_NONE) begin
                mem_we_q   <= src_d != SRC_HR;
                mem_addr_q <= addr_d;
            end
            if (src_d == SRC_RES || src_d == SRC_HW) mem_wdata_q <= wdata_d;
        end
    end

    assign bus.hw_ready  = ~full;
    assign bus.hr_ready  = src_d == SRC_HR;
    assign bus.hr_rvalid = rvalid_q;
    assign bus.hr_rdata  = rvalid_q ? bus.mem_rdata : '0;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.gnt_src   = gnt_q;
    assign bus.idle      = empty & ~rd_inflight_q & ~bus.res_valid;
endmodule

// File: tb/tb_scratchpad_port_arbiter.sv
// tb_scratchpad_port_arbiter: directed and random stimulus checked against a queue-based arbitration model
module tb_scratchpad_port_arbiter;
    localparam int AW = 10, DW = 16, DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    scratchpad_port_arbiter_if #(.ADDR_SIZE(AW), .WORD_SIZE(DW)) bus ();
    scratchpad_port_arbiter #(.ADDR_SIZE(AW), .WORD_SIZE(DW), .WFIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    bit [DW-1:0] ram [1024];
    bit [DW-1:0] ram_q;
    always @(posedge clk)
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else ram_q <= ram[bus.mem_addr];
        end
    assign bus.mem_rdata = ram_q;

    typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
    wr_t         q[$];
    bit [DW-1:0] mm [1024];
    bit          read_turn, acc_w, acc_r;
    int          cyc, rd_grant, checks, errors;
    int          src_cnt [4];
    logic          exp_en, exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, exp_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        read_turn = 0;
        rd_grant  = -10;
        exp_en = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0;
    endtask

    task automatic set_in(input bit r, input logic [AW-1:0] ra, input logic [DW-1:0] rd,
                          input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input bit h, input logic [AW-1:0] ha);
        bus.res_valid = r; bus.res_addr = ra; bus.res_data = rd;
        bus.hw_valid  = w; bus.hw_addr  = wa; bus.hw_data  = wd;
        bus.hr_valid  = h; bus.hr_addr  = ha;
    endtask

    // One clock: predict handshakes from the current inputs, then the registered RAM side.
    task automatic cycle();
        bit full, push, haz, rd_ok, wr_ok;
        int src;
        #1;
        full  = q.size() == DEPTH;
        push  = bus.hw_valid && !full;
        haz   = push && bus.hw_addr == bus.hr_addr;
        foreach (q[i]) if (q[i].a == bus.hr_addr) haz = 1;
        rd_ok = bus.hr_valid && !haz && cyc != rd_grant + 1;
        wr_ok = q.size() != 0;
        if (bus.res_valid) src = 1;
        else if (wr_ok && rd_ok) begin
            src = read_turn ? 3 : 2;
            read_turn = (src == 2);
        end else src = wr_ok ? 2 : rd_ok ? 3 : 0;
        chk("hw_ready", bus.hw_ready, !full);
        chk("hr_ready", bus.hr_ready, src == 3);
        chk("idle", bus.idle, !wr_ok && cyc != rd_grant + 1 && !bus.res_valid);
        acc_w = push;
        acc_r = src == 3;
        case (src)
            1: begin exp_we = 1; exp_addr = bus.res_addr; exp_wdata = bus.res_data; mm[bus.res_addr] = bus.res_data; end
            2: begin exp_we = 1; exp_addr = q[0].a; exp_wdata = q[0].d; mm[q[0].a] = q[0].d; void'(q.pop_front()); end
            3: begin exp_we = 0; exp_addr = bus.hr_addr; exp_rdata = mm[bus.hr_addr]; rd_grant = cyc; end
            default: ;
        endcase
        if (push) q.push_back('{a: bus.hw_addr, d: bus.hw_data});
        exp_en = src != 0;
        @(posedge clk);
        #1;
        cyc++;
        src_cnt[bus.gnt_src]++;
        chk("mem_en", bus.mem_en, exp_en);
        chk("gnt_src", bus.gnt_src, src);
        chk("mem_we", bus.mem_we, exp_we);
        chk("mem_addr", bus.mem_addr, exp_addr);
        if (src != 3) chk("mem_wdata", bus.mem_wdata, exp_wdata);
        chk("hr_rvalid", bus.hr_rvalid, rd_grant == cyc - 2);
        if (rd_grant == cyc - 2) chk("hr_rdata", bus.hr_rdata, exp_rdata);
    endtask

    task automatic idle_cycles(input int n);
        set_in(0, '0, '0, 0, '0, '0, 0, '0);
        repeat (n) cycle();
    endtask

    initial begin
        logic [AW-1:0] wa, ha;
        int nmis;
        set_in(0, '0, '0, 0, '0, '0, 0, '0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_gnt_src", bus.gnt_src, 0);
        chk("rst_hr_rvalid", bus.hr_rvalid, 0);
        chk("rst_hr_rdata", bus.hr_rdata, 0);
        chk("rst_hw_ready", bus.hw_ready, 1);
        chk("rst_idle", bus.idle, 1);
        rst_n = 1'b1;
        idle_cycles(2);

        // read latency: preload 0x0AB then a single read
        set_in(1, 10'h0AB, 16'h1234, 0, '0, '0, 0, '0);
        cycle();
        set_in(0, '0, '0, 0, '0, '0, 1, 10'h0AB);
        cycle();
        chk("lat_granted", acc_r, 1);
        idle_cycles(4);

        // result priority over both host ports
        wa = 10'h040; ha = 10'h080;
        for (int i = 0; i < 10; i++) begin
            set_in(i < 3, AW'(10'h200 + i), DW'(16'hA000 + i), 1, wa, {6'h14, wa}, 1, ha);
            cycle();
            if (acc_w) wa++;
            if (acc_r) ha++;
        end
        idle_cycles(8);

        // FIFO fills behind six result writes
        wa = 10'h010;
        for (int i = 0; i < 16; i++) begin
            set_in(i < 6, AW'(10'h210 + i), DW'(16'hB000 + i), wa <= 10'h015, wa, {6'h30, wa}, 0, '0);
            cycle();
            if (acc_w) wa++;
        end
        idle_cycles(3);
        for (int k = 0; k < 6; k++) chk("full_order", ram[10'h010 + k], 16'hC010 + k);

        // read-after-write hazard on 0x020
        set_in(1, 10'h230, 16'h0001, 1, 10'h020, 16'hBEEF, 0, '0);
        cycle();
        set_in(1, 10'h231, 16'h0002, 0, '0, '0, 1, 10'h020);
        cycle();
        set_in(0, '0, '0, 0, '0, '0, 1, 10'h020);
        for (int i = 0; i < 10 && !acc_r; i++) cycle();
        chk("haz_granted", acc_r, 1);
        idle_cycles(4);
        chk("haz_ram", ram[10'h020], 16'hBEEF);

        // round-robin under continuous contention
        for (int s = 0; s < 4; s++) src_cnt[s] = 0;
        wa = 10'h300; ha = 10'h340;
        for (int i = 0; i < 24; i++) begin
            set_in(0, '0, '0, 1, wa, {6'h0F, wa}, 1, ha);
            cycle();
            if (acc_w) wa++;
            if (acc_r) ha++;
        end
        chk("rr_hw_served", src_cnt[2] >= 8, 1);
        chk("rr_hr_served", src_cnt[3] >= 6, 1);
        idle_cycles(8);

        // random traffic on a small address window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 9) < 3, AW'($urandom_range(0, 15)), DW'($urandom),
                   $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)), DW'($urandom),
                   $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)));
            cycle();
        end
        idle_cycles(8);
        nmis = 0;
        for (int k = 0; k < 1024; k++) if (ram[k] != mm[k]) nmis++;
        chk("ram_image", nmis, 0);

        // reset discards queued writes
        set_in(1, 10'h3F0, 16'h0003, 1, 10'h3E0, 16'h7777, 0, '0);
        cycle();
        cycle();
        rst_n = 1'b0;
        set_in(0, '0, '0, 0, '0, '0, 0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        chk("rst2_hw_ready", bus.hw_ready, 1);
        chk("rst2_idle", bus.idle, 1);
        idle_cycles(4);
        chk("rst2_no_write", ram[10'h3E0], 0);

        // reset while a read is being granted
        set_in(0, '0, '0, 0, '0, '0, 1, 10'h0AB);
        #1;
        chk("rst3_hr_ready", bus.hr_ready, 1);
        rst_n = 1'b0;
        #1;
        chk("rst3_mem_en", bus.mem_en, 0);
        chk("rst3_gnt_src", bus.gnt_src, 0);
        bus.hr_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        chk("rst3_idle", bus.idle, 1);
        idle_cycles(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
